byte_serial_addsub64: RTL and testbench
=======================================

Name: byte_serial_addsub64

Overview:
- Sequential 64-bit add/subtract unit that drives one 8-bit ripple-carry slice adder per clock cycle, least significant byte first.
- A carry register links consecutive bytes, so a full 64-bit result takes 8 slice cycles.
- Sits between the ALU control path (start/op) and the 8-bit adder slice, giving the ALU a small-area ADD/SUB path with a start/done handshake and status flags.

Parameters:
- WIDTH, 64, operand/result width. Must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle. Fixed to the width of the 8-bit slice adder.
- NSLICES, WIDTH/SLICE (8), derived number of iterations. Not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  1  0 = x+y, 1 = x-y; sampled with start
- x  input  64  operand A; sampled with start
- y  input  64  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result and flags valid
- z  output  64  result register
- c_out  output  1  carry out of bit 63 (for SUB: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  z == 0

Behaviour:
- Reset (rst_b low, asynchronous): state=IDLE, z=0, c_out=0, ovf=0, zero=0, busy=0, done=0. Counter, carry register and operand registers are cleared. Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch a=x and b=(op ? ~y : y);
  - carry=op (supplies the +1 of two's-complement subtraction);
  - cnt=0;
  - go to RUN.
  - start=0 keeps IDLE.
- RUN, at each edge Ek (k=1..8):
  - slice adder inputs: a[8*cnt+7:8*cnt], b[8*cnt+7:8*cnt], carry;
  - write the slice sum into z[8*cnt+7:8*cnt];
  - carry <= slice c_out;
  - cnt <= cnt+1.
  - The slice is purely combinational; the byte is registered in the same edge.
- RUN → DONE at E8 (cnt==7):
  - c_out = slice carry out;
  - ovf = (a[63]==b[63]) && (z_new[63]!=a[63]), where b is the already-inverted operand;
  - zero = (full new z == 0).
- DONE lasts exactly one cycle:
  - done=1, busy=1;
  - at E9 go to IDLE, done=0, busy=0.
- Latency: start sampled at E0 → done high in the cycle after E8, for one cycle. Throughput is one operation per 10 cycles.
- start while busy (RUN or DONE) is ignored; operands are not re-latched and the result is not disturbed.
- Input stability: x, y, op may change freely after E0; internal copies are used.
- z, c_out, ovf, zero hold their values after done until the next accepted start. On the next accepted start they are not cleared; bytes are overwritten progressively, and flags update only at completion.
- Wrap-around: results are modulo 2^64, with the carry reported in c_out.
- Partial z bytes are visible during RUN and are not guaranteed meaningful until done.

Test Plan:
- Reset mid-run: start ADD, assert rst_b=0 after E4 → all outputs 0, IDLE, no done pulse. After release, a new start operates normally.
- Carry ripple across all bytes: ADD x=64'h00FF_FFFF_FFFF_FFFF, y=1 → z=64'h0100_0000_0000_0000, c_out=0, ovf=0, zero=0. done high exactly in the cycle after E8.
- Unsigned wrap: ADD x=64'hFFFF_FFFF_FFFF_FFFF, y=1 → z=0, c_out=1, zero=1, ovf=0.
- Signed overflow: ADD x=64'h7FFF_FFFF_FFFF_FFFF, y=1 → z=64'h8000_0000_0000_0000, ovf=1, c_out=0.
- Subtraction with borrow: SUB x=5, y=7 → z=64'hFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0. SUB x=7, y=7 → z=0, zero=1, c_out=1.
- Start during busy: second start with different x/y at E3 and again during DONE → ignored; first result unchanged. A start issued after returning to IDLE is accepted.

Source files
------------

// File: rtl/byte_serial_addsub64.sv
// Sequential WIDTH-bit add/subtract built around one SLICE-bit ripple adder,
// processing one slice per cycle, least significant slice first.
module byte_serial_addsub64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSLICES = WIDTH / SLICE;
    localparam int unsigned CntW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NSLICES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [SLICE-1:0]  slice_a;
    logic [SLICE-1:0]  slice_b;
    logic [SLICE:0]    slice_sum;

    // The single slice adder; carry_q links it to the previous slice.
    always_comb begin
        slice_a   = a_q[cnt_q*SLICE +: SLICE];
        slice_b   = b_q[cnt_q*SLICE +: SLICE];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = x;
                    // Subtraction as a + ~b + 1, the +1 entering as the initial carry.
                    b_d     = op ? ~y : y;
                    carry_d = op;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                z_d[cnt_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
                carry_d                   = slice_sum[SLICE];
                cnt_d                     = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    c_out_d = slice_sum[SLICE];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (z_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (z_d == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign z     = z_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_byte_serial_addsub64.sv
// Directed bench for byte_serial_addsub64: reset, abort, carry ripple, wrap,
// signed overflow, subtraction and start-while-busy handling.
module tb_byte_serial_addsub64;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic        op;
    logic [63:0] x;
    logic [63:0] y;
    logic        busy;
    logic        done;
    logic [63:0] z;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int tests = 0;
    int fails = 0;

    byte_serial_addsub64 dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .op    (op),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .c_out (c_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request before edge E0 and returns #1 after it, scrambling inputs.
    task automatic launch(input logic o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op    = o;
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        x     = {$urandom, $urandom};
        y     = {$urandom, $urandom};
    endtask

    // Counts edges until done is seen; expected count confirms the latency.
    task automatic wait_done(input string tag, input int expected_edges);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        check(tag, 64'(n), 64'(expected_edges));
    endtask

    task automatic check_result(input string tag, input logic [63:0] ez, input logic ec,
                                input logic eo, input logic ezr);
        check({tag, "_z"}, z, ez);
        check({tag, "_cout"}, 64'(c_out), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        check({tag, "_zero"}, 64'(zero), 64'(ezr));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int done_seen;
        rst_b = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        x     = '0;
        y     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_z", z, 64'd0);
        check("rst_cout", 64'(c_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // Abort mid-run after E4.
        launch(1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        repeat (4) @(posedge clk);
        #1;
        check("abort_partial_z_busy", 64'(busy), 64'd1);
        rst_b = 1'b0;
        #1;
        check("abort_z", z, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_flags", {61'd0, c_out, ovf, zero}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        launch(1'b0, 64'd10, 64'd20);
        wait_done("post_abort_latency", 8);
        check_result("post_abort", 64'd30, 1'b0, 1'b0, 1'b0);

        launch(1'b0, 64'h00FF_FFFF_FFFF_FFFF, 64'd1);
        wait_done("ripple_latency", 8);
        check_result("ripple", 64'h0100_0000_0000_0000, 1'b0, 1'b0, 1'b0);

        launch(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done("wrap_latency", 8);
        check_result("wrap", 64'd0, 1'b1, 1'b0, 1'b1);

        launch(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done("sovf_latency", 8);
        check_result("sovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

        launch(1'b1, 64'd5, 64'd7);
        wait_done("sub_borrow_latency", 8);
        check_result("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

        launch(1'b1, 64'd7, 64'd7);
        wait_done("sub_equal_latency", 8);
        check_result("sub_equal", 64'd0, 1'b1, 1'b0, 1'b1);

        // Result and flags must hold while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_z", z, 64'd0);
        check("hold_zero", 64'(zero), 64'd1);

        // Start requests during RUN (at E3) and DONE (at E9) must be ignored.
        launch(1'b0, 64'd3, 64'd4);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        x     = 64'd100;
        y     = 64'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_latency", 5);
        check("busy_z_at_done", z, 64'd7);
        check("busy_flags_at_done", {61'd0, c_out, ovf, zero}, 64'd0);
        start = 1'b1;
        op    = 1'b0;
        x     = 64'hDEAD_BEEF_0000_0000;
        y     = 64'h0000_0000_CAFE_F00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_done_start_idle", 64'(busy), 64'd0);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (busy) done_seen++;
        end
        check("busy_no_restart", 64'(done_seen), 64'd0);
        check("busy_z_kept", z, 64'd7);

        launch(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
        wait_done("after_busy_latency", 8);
        check_result("after_busy", 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
